// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/halt/step debug controller.
package cpu_dbg_pkg;

    localparam int PC_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-clk pulse when the debounced level rises.
module btn_debounce #(
    parameter int DB_LEN = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DB_LEN);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             w_btn;

    assign w_btn = r_sync[1];

    // NOTE: async reset in the sensitivity list, and <= for every register so
    // all of them sample the pre-edge values of each other.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_i};
            r_rise <= 1'b0;
            if (w_btn == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_LEN - 1)) begin
                // DB_LEN consecutive samples disagreed with the held level
                r_cnt   <= '0;
                r_level <= w_btn;
                r_rise  <= w_btn;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: gates the divider tick into the CPU clock
// enable, with a fetch-PC breakpoint and a retired-step counter.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DB_LEN = 1_000_000,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tick,
    input  logic            run_sw,
    input  logic            step_btn,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc_if,
    input  logic            clr_cnt,
    output logic            cpu_ce,
    output logic            halted,
    output logic            bp_hit,
    output logic [1:0]      state_o,
    output logic [31:0]     step_cnt
);

    logic [1:0]  r_run_sync;
    run_state_e  r_state;
    logic        r_skip_bp;
    logic [31:0] r_step_cnt;
    logic        w_run;
    logic        w_step_p;
    logic        w_stop;
    logic        w_unused_db_level;

    btn_debounce #(.DB_LEN(DB_LEN)) u_step_db (
        .clk     (clk),
        .rstn    (rstn),
        .btn_i   (step_btn),
        .level_o (w_unused_db_level),
        .rise_o  (w_step_p)
    );

    assign w_run = r_run_sync[1];

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_stop = bp_en && (pc_if == bp_addr) && !r_skip_bp;
        case (r_state)
            ST_RUN:  cpu_ce = tick && !w_stop;
            ST_STEP: cpu_ce = tick;
            default: cpu_ce = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run_sync <= '0;
            r_state    <= ST_HALT;
            r_skip_bp  <= 1'b0;
        end else begin
            r_run_sync <= {r_run_sync[0], run_sw};
            case (r_state)
                ST_HALT: begin
                    if (w_step_p) begin
                        r_state <= ST_STEP;
                    end else if (w_run) begin
                        r_state   <= ST_RUN;
                        r_skip_bp <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Resuming on the breakpoint PC lets exactly one fetch through
                    if (cpu_ce) r_skip_bp <= 1'b0;
                    if (tick && w_stop) r_state <= ST_BREAK;
                    else if (!w_run)    r_state <= ST_HALT;
                end
                ST_STEP: begin
                    if (tick) r_state <= ST_HALT;
                end
                ST_BREAK: begin
                    if (w_step_p)    r_state <= ST_STEP;
                    else if (!w_run) r_state <= ST_HALT;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_step_cnt <= '0;
        else if (clr_cnt) r_step_cnt <= '0;
        else if (cpu_ce)  r_step_cnt <= r_step_cnt + 32'd1;
    end

    assign halted   = (r_state == ST_HALT) || (r_state == ST_BREAK);
    assign bp_hit   = (r_state == ST_BREAK);
    assign state_o  = r_state;
    assign step_cnt = r_step_cnt;

endmodule
